// File: rtl/snake_defs.sv
// Shared direction encoding for the snake game blocks.
package snake_defs;

  localparam int DIR_W = 2;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular buffer of pending turns; exposes head (next to apply) and
// tail (newest entry) so the caller can compare presses against it.
module dir_fifo
  import snake_defs::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  dir_t       din,
  input  logic       pop,
  output dir_t       head,
  output dir_t       tail,
  output logic [2:0] count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

  dir_t          mem_q [QDEPTH];
  dir_t          mem_d [QDEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [2:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Caller guarantees push only when not full and pop only when not empty.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = inc(wr_q);
      end
      if (pop) begin
        rd_d = inc(rd_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 3'd1;
        2'b01:   cnt_d = cnt_q - 3'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign tail  = (wr_q == '0) ? mem_q[LAST] : mem_q[wr_q - 1'b1];
  assign count = cnt_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Converts button press pulses into the snake's direction, queueing turns
// between game steps and rejecting repeats and reversals.
module snake_dir_ctrl
  import snake_defs::*;
#(
  parameter int   QDEPTH   = 2,
  parameter dir_t INIT_DIR = DIR_RIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       run,
  input  logic       clear,
  input  logic       step_tick,
  output dir_t       dir,
  output logic       dir_changed,
  output logic [2:0] pending,
  output logic       key_drop
);

  localparam logic [2:0] FULL_CNT = 3'(QDEPTH);

  dir_t       dir_q, dir_d;
  logic       dir_changed_q, dir_changed_d;
  logic       key_drop_q, key_drop_d;

  logic       press;
  dir_t       key;
  dir_t       ref_dir;
  logic       push, pop;
  dir_t       head, tail;
  logic [2:0] count;

  dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push),
    .din   (key),
    .pop   (pop),
    .head  (head),
    .tail  (tail),
    .count (count)
  );

  always_comb begin
    press = btn_up | btn_right | btn_down | btn_left;
    if (btn_up)         key = DIR_UP;
    else if (btn_right) key = DIR_RIGHT;
    else if (btn_down)  key = DIR_DOWN;
    else                key = DIR_LEFT;

    // Presses are judged against the last turn the snake will have made.
    ref_dir = (count != 3'd0) ? tail : dir_q;

    push       = 1'b0;
    key_drop_d = 1'b0;
    if (run && press && (key != ref_dir)) begin
      if (key == opposite(ref_dir)) key_drop_d = 1'b1;
      else if (count == FULL_CNT)   key_drop_d = 1'b1;
      else                          push       = 1'b1;
    end

    pop           = run && step_tick && (count != 3'd0);
    dir_d         = pop ? head : dir_q;
    dir_changed_d = pop;

    if (clear) begin
      push          = 1'b0;
      pop           = 1'b0;
      dir_d         = INIT_DIR;
      dir_changed_d = 1'b0;
      key_drop_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q         <= INIT_DIR;
      dir_changed_q <= 1'b0;
      key_drop_q    <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      key_drop_q    <= key_drop_d;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;
  assign key_drop    = key_drop_q;
  assign pending     = count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Table-driven and randomized checks of snake_dir_ctrl with a result scoreboard.
module tb_snake_dir_ctrl;
  localparam int QDEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_right, btn_down, btn_left;
  logic       run, clear, step_tick;
  logic [1:0] dir;
  logic       dir_changed, key_drop;
  logic [2:0] pending;

  snake_dir_ctrl #(.QDEPTH(QDEPTH), .INIT_DIR(2'd1)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .run(run), .clear(clear), .step_tick(step_tick),
    .dir(dir), .dir_changed(dir_changed), .pending(pending), .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;   // {up, right, down, left}
    logic       run;
    logic       clr;
    logic       tick;
    logic [1:0] edir;
    logic [2:0] epend;
    logic       echg;
    logic       edrop;
  } vec_t;

  typedef struct {
    logic [1:0] dir;
    logic [2:0] pend;
    logic       chg;
    logic       drop;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state for the random phase
  logic [1:0] m_dir;
  logic [1:0] m_q[$];

  function automatic vec_t V(logic [3:0] b, logic r, logic c, logic t,
                             logic [1:0] d, logic [2:0] p, logic ch, logic dr);
    vec_t v;
    v.btn = b; v.run = r; v.clr = c; v.tick = t;
    v.edir = d; v.epend = p; v.echg = ch; v.edrop = dr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".dir"}, int'(dir), int'(e.dir));
    chk({tag, ".pending"}, int'(pending), int'(e.pend));
    chk({tag, ".dir_changed"}, int'(dir_changed), int'(e.chg));
    chk({tag, ".key_drop"}, int'(key_drop), int'(e.drop));
  endtask

  task automatic drive(input logic r, input logic [3:0] b, input logic rn,
                       input logic c, input logic t, input exp_t e, input string tag);
    rst = r;
    {btn_up, btn_right, btn_down, btn_left} = b;
    run = rn; clear = c; step_tick = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    e.dir = v.edir; e.pend = v.epend; e.chg = v.echg; e.drop = v.edrop;
    drive(1'b1, v.btn, v.run, v.clr, v.tick, e, $sformatf("vec%0d", idx));
  endtask

  // Model one clock of the controller; returns the expected registered outputs.
  function automatic exp_t model_step(logic [3:0] b, logic rn, logic c, logic t);
    exp_t e;
    logic [1:0] k, rd;
    logic do_push;
    e.chg = 1'b0; e.drop = 1'b0; do_push = 1'b0;
    if (c) begin
      m_dir = 2'd1;
      m_q.delete();
    end else if (rn) begin
      k = b[3] ? 2'd0 : b[2] ? 2'd1 : b[1] ? 2'd2 : 2'd3;
      rd = (m_q.size() > 0) ? m_q[$] : m_dir;
      if (b != 4'b0 && k != rd) begin
        if (k == {~rd[1], rd[0]})      e.drop = 1'b1;
        else if (m_q.size() == QDEPTH) e.drop = 1'b1;
        else                           do_push = 1'b1;
      end
      if (t && m_q.size() > 0) begin
        m_dir = m_q.pop_front();
        e.chg = 1'b1;
      end
      if (do_push) m_q.push_back(k);
    end
    e.dir = m_dir;
    e.pend = 3'(m_q.size());
    return e;
  endfunction

  initial begin
    exp_t e;
    rst = 1'b0;
    {btn_up, btn_right, btn_down, btn_left} = 4'b0;
    run = 1'b1; clear = 1'b0; step_tick = 1'b0;

    // test 1: press up, tick five cycles later
    tbl.push_back(V(4'h0,1,0,0, 1,0,0,0));
    tbl.push_back(V(4'h8,1,0,0, 1,1,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(V(4'h0,1,0,0, 1,1,0,0));
    tbl.push_back(V(4'h0,1,0,1, 0,0,1,0));
    tbl.push_back(V(4'h0,1,0,0, 0,0,0,0));
    tbl.push_back(V(4'h4,1,0,0, 0,1,0,0));
    tbl.push_back(V(4'h0,1,0,1, 1,0,1,0));
    // test 2: reversal while heading right
    tbl.push_back(V(4'h1,1,0,0, 1,0,0,1));
    tbl.push_back(V(4'h0,1,0,0, 1,0,0,0));
    tbl.push_back(V(4'h0,1,0,1, 1,0,0,0));
    // test 3: double tap up, left
    tbl.push_back(V(4'h8,1,0,0, 1,1,0,0));
    tbl.push_back(V(4'h1,1,0,0, 1,2,0,0));
    tbl.push_back(V(4'h0,1,0,1, 0,1,1,0));
    tbl.push_back(V(4'h0,1,0,1, 3,0,1,0));
    tbl.push_back(V(4'h0,1,0,1, 3,0,0,0));
    // test 4: overflow with concurrent pop
    tbl.push_back(V(4'h8,1,0,0, 3,1,0,0));
    tbl.push_back(V(4'h1,1,0,0, 3,2,0,0));
    tbl.push_back(V(4'h2,1,0,1, 0,1,1,1));
    tbl.push_back(V(4'h0,1,0,1, 3,0,1,0));
    // test 5: back to right, then simultaneous up+left, repeat, reversal vs tail
    tbl.push_back(V(4'h8,1,0,0, 3,1,0,0));
    tbl.push_back(V(4'h0,1,0,1, 0,0,1,0));
    tbl.push_back(V(4'h4,1,0,0, 0,1,0,0));
    tbl.push_back(V(4'h0,1,0,1, 1,0,1,0));
    tbl.push_back(V(4'h9,1,0,0, 1,1,0,0));
    tbl.push_back(V(4'h8,1,0,0, 1,1,0,0));
    tbl.push_back(V(4'h2,1,0,0, 1,1,0,1));
    // test 6: clear with pending=2, then run=0 holds everything
    tbl.push_back(V(4'h1,1,0,0, 1,2,0,0));
    tbl.push_back(V(4'h8,1,1,1, 1,0,0,0));
    tbl.push_back(V(4'h8,0,0,1, 1,0,0,0));
    tbl.push_back(V(4'h8,1,0,0, 1,1,0,0));
    tbl.push_back(V(4'h0,0,0,1, 1,1,0,0));
    tbl.push_back(V(4'h2,0,0,0, 1,1,0,0));
    tbl.push_back(V(4'h0,1,0,1, 0,0,1,0));
    // no bypass: press and tick together on an empty queue
    tbl.push_back(V(4'h4,1,0,1, 0,1,0,0));
    tbl.push_back(V(4'h0,1,0,1, 1,0,1,0));
    // push and pop in one cycle keep pending
    tbl.push_back(V(4'h8,1,0,0, 1,1,0,0));
    tbl.push_back(V(4'h1,1,0,1, 0,1,1,0));
    tbl.push_back(V(4'h0,1,0,1, 3,0,1,0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset.dir", int'(dir), 1);
    chk("reset.pending", int'(pending), 0);
    chk("reset.dir_changed", int'(dir_changed), 0);
    chk("reset.key_drop", int'(key_drop), 0);

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // synchronous reset mid-game discards the queue and any press that cycle
    e.dir = 2'd3; e.pend = 3'd1; e.chg = 1'b0; e.drop = 1'b0;
    drive(1'b1, 4'h8, 1'b1, 1'b0, 1'b0, e, "rst_pre");
    e.dir = 2'd1; e.pend = 3'd0;
    drive(1'b0, 4'h4, 1'b1, 1'b0, 1'b1, e, "rst_mid");
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, e, "rst_post");

    // randomized phase against the reference model
    m_dir = 2'd1;
    m_q.delete();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] b;
      logic rn, c, t;
      b  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = 4'h0;
      rn = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 2) == 0);
      e  = model_step(b, rn, c, t);
      drive(1'b1, b, rn, c, t, e, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
